// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution front-end stream stages.
package conv_pkg;

  localparam int unsigned DATA_W   = 20;
  localparam int unsigned NUM_FILT = 32;
  localparam int unsigned KER_LEN  = 27;

  typedef enum logic [1:0] {
    IDLE,
    KER,
    BIAS,
    DRAIN
  } state_t;

  typedef struct packed {
    logic              is_bias;
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; push and pop may occur
// in the same cycle (a push into a full FIFO is accepted only alongside a pop).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kernel_bias_loader.sv
// Fetches one filter's 27 kernel weights and its bias from the BRAM bank and
// streams them to the convolution engine through a credit-limited FIFO.
module kernel_bias_loader #(
  parameter int unsigned DATA_W      = conv_pkg::DATA_W,
  parameter int unsigned KER_ADDR_W  = 5,
  parameter int unsigned BIAS_ADDR_W = 5,
  parameter int unsigned NUM_FILT    = conv_pkg::NUM_FILT,
  parameter int unsigned KER_LEN     = conv_pkg::KER_LEN,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(NUM_FILT)-1:0]  filt_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         ram_enable,
  output logic [KER_ADDR_W-1:0]        ker_addr,
  input  logic [NUM_FILT*DATA_W-1:0]   ker_rdata,
  output logic [BIAS_ADDR_W-1:0]       bias_addr,
  input  logic [DATA_W-1:0]            bias_rdata,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_is_bias,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready
);

  import conv_pkg::*;

  localparam int unsigned FILT_W = $clog2(NUM_FILT);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [KER_ADDR_W-1:0] LAST_KER = KER_ADDR_W'(KER_LEN - 1);

  state_t            state;
  state_t            state_next;
  logic [FILT_W-1:0] filt_q;
  logic              issue;
  logic              can_issue;
  logic              inflight;
  logic              rd_bias;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              last_accept;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  // A read is only launched when every outstanding word still has a free slot.
  assign can_issue   = ((int'(fifo_count) + int'(inflight)) < (int'(FIFO_DEPTH) - 1)) & ~fifo_full;
  assign pop         = m_valid & m_ready;
  assign last_accept = pop & head.last;
  assign busy        = (state != IDLE);
  assign ram_enable  = issue;

  assign m_valid     = ~fifo_empty;
  assign m_data      = head.data;
  assign m_is_bias   = head.is_bias;
  assign m_last      = head.last;

  assign push_entry.is_bias = rd_bias;
  assign push_entry.last    = rd_bias;
  assign push_entry.data    = rd_bias ? bias_rdata : ker_rdata[filt_q*DATA_W +: DATA_W];

  // Next-state and read-issue decode.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = KER;
      end
      KER: begin
        if (can_issue) begin
          issue = 1'b1;
          if (ker_addr == LAST_KER) state_next = BIAS;
        end
      end
      BIAS: begin
        if (can_issue) begin
          issue      = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, address generation, read pipeline tag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      filt_q    <= '0;
      ker_addr  <= '0;
      bias_addr <= '0;
      inflight  <= 1'b0;
      rd_bias   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      rd_bias  <= issue & (state == BIAS);
      done     <= (state == DRAIN) & last_accept;
      if ((state == IDLE) && start) begin
        filt_q    <= filt_idx;
        bias_addr <= BIAS_ADDR_W'(filt_idx);
        ker_addr  <= '0;
      end else if ((state == KER) && issue && (ker_addr != LAST_KER)) begin
        ker_addr <= ker_addr + 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_kernel_bias_loader.sv
// Directed bench for kernel_bias_loader with behavioural kernel/bias BRAMs.
module tb_kernel_bias_loader;

  localparam int unsigned DW = 20;
  localparam int unsigned NF = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [4:0]       filt_idx;
  logic             busy;
  logic             done;
  logic             ram_enable;
  logic [4:0]       ker_addr;
  logic [NF*DW-1:0] ker_rdata;
  logic [4:0]       bias_addr;
  logic [DW-1:0]    bias_rdata;
  logic [DW-1:0]    m_data;
  logic             m_is_bias;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  kernel_bias_loader #(
    .DATA_W      (20),
    .KER_ADDR_W  (5),
    .BIAS_ADDR_W (5),
    .NUM_FILT    (32),
    .KER_LEN     (27),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .filt_idx   (filt_idx),
    .busy       (busy),
    .done       (done),
    .ram_enable (ram_enable),
    .ker_addr   (ker_addr),
    .ker_rdata  (ker_rdata),
    .bias_addr  (bias_addr),
    .bias_rdata (bias_rdata),
    .m_data     (m_data),
    .m_is_bias  (m_is_bias),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: kernel[f][a] = f*256 + a, bias[f] = 0xB0000 + f, 1-cycle registered read.
  initial begin
    ker_rdata  = '0;
    bias_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_enable) begin
      for (int f = 0; f < NF; f++) ker_rdata[f*DW +: DW] <= DW'(f * 256 + int'(ker_addr));
      bias_rdata <= 20'hB0000 + DW'(bias_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      32'(busy),       0);
    check({tag, "_done"},      32'(done),       0);
    check({tag, "_ram_en"},    32'(ram_enable), 0);
    check({tag, "_m_valid"},   32'(m_valid),    0);
    check({tag, "_m_is_bias"}, 32'(m_is_bias),  0);
    check({tag, "_m_last"},    32'(m_last),     0);
    check({tag, "_ker_addr"},  32'(ker_addr),   0);
    check({tag, "_bias_addr"}, 32'(bias_addr),  0);
    check({tag, "_m_data"},    32'(m_data),     0);
  endtask

  // Called at a negedge. mode 0: ready always, 1: ready toggles, 2: ready low for 20 cycles.
  // restart re-pulses start with filter 9 mid-load; linger watches 5 cycles past done.
  task automatic run_load(input int unsigned filt, input int unsigned mode,
                          input bit restart, input bit linger);
    int unsigned idx, first_v, last_v, done_k, done_cnt, reads, max_cnt;
    logic [31:0] exp;
    bit stop;
    idx = 0; first_v = 0; last_v = 0; done_k = 0; done_cnt = 0; reads = 0; max_cnt = 0;
    stop = 1'b0;
    filt_idx = 5'(filt);
    start    = 1'b1;
    m_ready  = (mode != 2);
    for (int unsigned k = 1; k <= 200 && !stop; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && k == 2) begin
        start    = 1'b1;
        filt_idx = 5'd9;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = k[0];
        default: m_ready = (k > 20);
      endcase
      if (ram_enable) reads++;
      if (int'(dut.fifo_count) > int'(max_cnt)) max_cnt = 32'(dut.fifo_count);
      if (mode == 2 && k == 20) check("reads_while_stalled", reads, 3);
      if (done) begin
        done_cnt++;
        if (done_k == 0) begin
          done_k = k;
          check("words_before_done", idx, 28);
        end
      end
      if (m_valid) begin
        if (first_v == 0) first_v = k;
        last_v = k;
        exp = (idx < 27) ? filt * 256 + idx : 32'hB0000 + filt;
        check($sformatf("f%0d_w%0d_data", filt, idx), 32'(m_data), exp);
        check($sformatf("f%0d_w%0d_bias", filt, idx), 32'(m_is_bias), 32'(idx >= 27));
        check($sformatf("f%0d_w%0d_last", filt, idx), 32'(m_last), 32'(idx >= 27));
        if (m_ready) idx++;
      end
      if (done_k != 0 && (!linger || k >= done_k + 5)) stop = 1'b1;
    end
    if (done_k == 0) check("done_timeout", 0, 1);
    check("word_count", idx, 28);
    check("done_pulses", done_cnt, 1);
    check("fifo_max_le3", 32'(max_cnt <= 3), 1);
    if (mode == 0) begin
      check("first_valid_cycle", first_v, 3);
      check("last_valid_cycle", last_v, 30);
      check("done_cycle", done_k, 31);
    end
  endtask

  // Mid-load reset: abort after the 10th accepted word.
  task automatic reset_abort();
    int unsigned idx;
    bit seen_done;
    idx = 0;
    seen_done = 1'b0;
    filt_idx = 5'd3;
    start    = 1'b1;
    m_ready  = 1'b1;
    for (int unsigned k = 1; k <= 100 && idx < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) idx++;
    end
    @(negedge clk);
    check("accepted_before_reset", idx, 10);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("no_done_after_abort", 32'(seen_done), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    filt_idx = '0;
    m_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_load(5, 0, 1'b0, 1'b1);
    run_load(31, 1, 1'b0, 1'b1);
    run_load(12, 2, 1'b0, 1'b1);
    run_load(2, 0, 1'b1, 1'b1);
    reset_abort();
    run_load(0, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
